// File: rtl/regwrite_trace_uart.sv
// regwrite_trace_uart: queues non-zero regfile writes and streams them as 8N1 UART frames.
// Latency: entry visible the edge after the regfile_clock rise; start bit begins one cycle later.
// Backpressure: none upstream; events that find the FIFO full are dropped and counted. Option: TRACE_TIMESTAMP_EN.
module regwrite_trace_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        regfile_clock,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,
    output logic        uart_tx,
    output logic        busy,
    output logic [7:0]  overflow_count
);

`ifdef TRACE_TIMESTAMP_EN
    localparam int         ENTRY_W = 53;
    localparam int         NBYTES  = 7;
    localparam logic [2:0] HDR     = 3'b110;
`else
    localparam int         ENTRY_W = 37;
    localparam int         NBYTES  = 5;
    localparam logic [2:0] HDR     = 3'b101;
`endif
    localparam int FRAME_W = NBYTES * 8;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int BAUD_W  = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               r_state, w_state_nxt;
    logic [FRAME_W-1:0]   r_shift, w_shift_nxt;
    logic [BAUD_W-1:0]    r_baud, w_baud_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic [2:0]           r_byte, w_byte_nxt;
    logic                 r_tx, w_tx_nxt;

    logic                 r_rfclk_q;
    logic [7:0]           r_ovf;
    logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W:0]       r_wr_ptr, r_rd_ptr;

    logic                 w_event, w_empty, w_full, w_push, w_pop, w_drop, w_baud_end;
    logic [ENTRY_W-1:0]   w_entry, w_head;
    logic [FRAME_W-1:0]   w_frame;

    assign w_event = regfile_clock && !r_rfclk_q && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;
    assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] r_ts;
    assign w_entry = {r_ts, ctrl_writeReg, data_writeReg};
    assign w_frame = {w_head[44:37], w_head[52:45], w_head[7:0], w_head[15:8],
                      w_head[23:16], w_head[31:24], HDR, w_head[36:32]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ts <= 16'd0;
        end else if (regfile_clock && !r_rfclk_q) begin
            r_ts <= r_ts + 16'd1;
        end
    end
`else
    assign w_entry = {ctrl_writeReg, data_writeReg};
    // Byte 0 sits in the low bits so the shifter always transmits from bit 0.
    assign w_frame = {w_head[7:0], w_head[15:8], w_head[23:16], w_head[31:24],
                      HDR, w_head[36:32]};
`endif

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rfclk_q <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ovf     <= 8'd0;
        end else begin
            r_rfclk_q <= regfile_clock;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
            end
            if (w_drop && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_byte  <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_frame;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_byte_nxt  = 3'd0;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_tx_nxt  = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_byte == 3'(NBYTES - 1)) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_byte_nxt  = r_byte + 3'd1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign uart_tx        = r_tx;
    assign busy           = !w_empty || (r_state != S_IDLE);
    assign overflow_count = r_ovf;

endmodule

// File: tb/tb_regwrite_trace_uart.sv
// Bench for regwrite_trace_uart: random and directed regfile writes, UART byte decoder with scoreboard.
module tb_regwrite_trace_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef TRACE_TIMESTAMP_EN
    localparam int         NB  = 7;
    localparam logic [2:0] HDR = 3'b110;
`else
    localparam int         NB  = 5;
    localparam logic [2:0] HDR = 3'b101;
`endif
    localparam int FRAME = NB * 10 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        regfile_clock = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wreg = 5'd0;
    logic [31:0] wdat = 32'd0;
    logic        uart_tx;
    logic        busy;
    logic [7:0]  ovf;

    regwrite_trace_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .regfile_clock    (regfile_clock),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wreg),
        .data_writeReg    (wdat),
        .uart_tx          (uart_tx),
        .busy             (busy),
        .overflow_count   (ovf)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    // Reference model: FIFO occupancy plus the earliest edge at which the serializer can pop again.
    int   cyc = 0;
    int   m_cnt = 0;
    int   m_next_pop = 0;
    int   m_ovf = 0;
    logic m_prev_rf = 1'b0;
    logic [15:0] m_ts = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            bit m_pop;
            bit m_rise;
            @(posedge clock);
            if (!reset) begin
                m_cnt = 0; m_next_pop = 0; m_ovf = 0; m_prev_rf = 1'b0; m_ts = 16'd0;
            end else begin
                m_pop  = (m_cnt > 0) && (cyc >= m_next_pop);
                m_rise = regfile_clock && !m_prev_rf;
                if (m_pop) begin
                    m_cnt--;
                    m_next_pop = cyc + FRAME + 1;
                end
                if (m_rise && we && (wreg != 5'd0)) begin
                    if (m_cnt < DEPTH) begin
                        m_cnt++;
                        exp_q.push_back({HDR, wreg});
                        exp_q.push_back(wdat[31:24]);
                        exp_q.push_back(wdat[23:16]);
                        exp_q.push_back(wdat[15:8]);
                        exp_q.push_back(wdat[7:0]);
`ifdef TRACE_TIMESTAMP_EN
                        exp_q.push_back(m_ts[15:8]);
                        exp_q.push_back(m_ts[7:0]);
`endif
                    end else if (m_ovf < 255) begin
                        m_ovf++;
                    end
                end
                if (m_rise) m_ts = m_ts + 16'd1;
                m_prev_rf = regfile_clock;
            end
            cyc++;
        end
    end

    task automatic rx_byte(output logic [7:0] b, output bit ok);
        b  = 8'd0;
        ok = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        if (!reset) return;
        check("start_bit", 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            if (!reset) return;
            b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clock);
        if (!reset) return;
        check("stop_bit", 32'(uart_tx), 32'd1);
        ok = 1'b1;
    endtask

    initial begin
        forever begin
            logic [7:0] b;
            bit ok;
            @(negedge clock);
            if (reset && uart_tx === 1'b0) begin
                rx_byte(b, ok);
                if (ok) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rx_unexpected: got byte %h, expected none", b);
                    end else begin
                        check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic rf_period(input logic we_edge, input logic we_hold,
                             input logic [4:0] r, input logic [31:0] d);
        @(negedge clock);
        regfile_clock = 1'b1; we = we_edge; wreg = r; wdat = d;
        @(negedge clock);
        we = we_hold;
        @(negedge clock);
        regfile_clock = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < bound) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (n >= bound) begin
            fails++;
            $display("FAIL drain_timeout: %0d bytes pending, busy=%b, required 0 and 0", exp_q.size(), busy);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("reset_tx", 32'(uart_tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single write r3 <- DEADBEEF with exact edge timing
        regfile_clock = 1'b1; we = 1'b1; wreg = 5'd3; wdat = 32'hDEADBEEF;
        @(negedge clock);
        check("busy_rise", 32'(busy), 32'd1);
        check("tx_before_start", 32'(uart_tx), 32'd1);
        regfile_clock = 1'b0; we = 1'b0;
        @(negedge clock);
        check("tx_start_fall", 32'(uart_tx), 32'd0);
        repeat (FRAME - 1) @(negedge clock);
        check("busy_last_cycle", 32'(busy), 32'd1);
        @(negedge clock);
        check("busy_fall", 32'(busy), 32'd0);
        check("frame_consumed", 32'(exp_q.size()), 32'd0);

        // Writes that must not produce events
        rf_period(1'b1, 1'b1, 5'd0, $urandom);
        check("no_evt_r0", 32'(busy), 32'd0);
        rf_period(1'b0, 1'b1, 5'd9, $urandom);
        check("no_evt_we_low_at_edge", 32'(busy), 32'd0);
        we = 1'b0;
        repeat (20) @(negedge clock);
        check("idle_tx", 32'(uart_tx), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Burst of 20 writes into a 16-deep FIFO
        for (int r = 1; r <= 20; r++) rf_period(1'b1, 1'b1, 5'(r), $urandom);
        we = 1'b0;
        check("ovf_burst", 32'(ovf), 32'(m_ovf));
        check("ovf_burst_three", 32'(ovf), 32'd3);
        wait_drain(6000);

        // Saturation of the drop counter
        for (int k = 0; k < 340; k++) rf_period(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom);
        we = 1'b0;
        check("ovf_sat_model", 32'(ovf), 32'(m_ovf));
        check("ovf_sat", 32'(ovf), 32'd255);

        // Reset while frames are in flight flushes everything
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("flush_tx", 32'(uart_tx), 32'd1);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ovf", 32'(ovf), 32'd0);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Reset during a zero data bit of byte 2
        regfile_clock = 1'b1; we = 1'b1; wreg = 5'd7; wdat = 32'h12345678;
        @(negedge clock);
        regfile_clock = 1'b0; we = 1'b0;
        repeat (100) @(negedge clock);
        check("tx_byte2_bit3", 32'(uart_tx), 32'(wdat[19]));
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("tx_async_reset", 32'(uart_tx), 32'd1);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        repeat (60) @(negedge clock);
        check("post_reset_tx", 32'(uart_tx), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);
        rf_period(1'b1, 1'b0, 5'd7, $urandom);
        wait_drain(6000);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            rf_period(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 250)) @(negedge clock);
        end
        we = 1'b0;
        check("ovf_random", 32'(ovf), 32'(m_ovf));
        wait_drain(6000);
        check("final_busy", 32'(busy), 32'd0);
        check("final_tx", 32'(uart_tx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
